// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift-add multiplier sequencer.
package mul_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Opcode on which the control unit raises start.
  localparam logic [3:0] MUL_OPCODE = 4'b1111;

endpackage

// File: rtl/mul_sequencer_dp.sv
// Shift-add datapath: multiplicand/multiplier/accumulator registers and the adder.
// i_load captures fresh operands; i_step performs one multiplier-bit iteration.
module mul_sequencer_dp #(
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_op_a,
  input  logic [WIDTH-1:0]   i_op_b,
  output logic [2*WIDTH-1:0] o_acc_next,
  output logic               o_mplr_zero
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   w_mplr_next;

  // Accumulator value after the current iteration (adds mcand when the low multiplier bit is set).
  assign o_acc_next  = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign w_mplr_next = r_mplr >> 1;
  // Multiplier is exhausted once the shifted value has no set bits left.
  assign o_mplr_zero = (w_mplr_next == '0);

  // Operand capture on load, shift/accumulate on step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
    end else if (i_load) begin
      r_mcand <= {{WIDTH{1'b0}}, i_op_a};
      r_mplr  <= i_op_b;
      r_acc   <= '0;
    end else if (i_step) begin
      r_acc   <= o_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= w_mplr_next;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier sequencer (one multiplier bit per clock).
// Optional build macro MUL_SEQUENCER_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero, and short-circuit a zero multiplier at acceptance.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [CNT_W-1:0]   iter_cnt
);

  state_e             r_state, w_state_next;
  logic [2*WIDTH-1:0] r_product;
  logic [CNT_W-1:0]   r_iter_cnt;

  logic               w_load;
  logic               w_step;
  logic               w_upd_product;
  logic [2*WIDTH-1:0] w_product_val;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_mplr_zero;
  logic               w_cnt_last;
  logic               w_finish;

  mul_sequencer_dp #(.WIDTH(WIDTH)) u_dp (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_acc_next  (w_acc_next),
    .o_mplr_zero (w_mplr_zero)
  );

  assign w_cnt_last = (r_iter_cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
  assign w_finish = w_cnt_last || w_mplr_zero;
`else
  // After the WIDTH-th shift the multiplier is always zero, so this equals w_cnt_last.
  assign w_finish = w_cnt_last && w_mplr_zero;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_step        = 1'b0;
    w_upd_product = 1'b0;
    w_product_val = w_acc_next;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ITER;
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
          if (op_b == '0) begin
            w_state_next  = DONE;
            w_upd_product = 1'b1;
            w_product_val = '0;
          end
`endif
        end else begin
          w_state_next = IDLE;
        end
      end
      ITER: begin
        w_step = 1'b1;
        if (w_finish) begin
          w_state_next  = DONE;
          w_upd_product = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Product holds the last result; iteration counter clears on accept, counts per step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_product  <= '0;
      r_iter_cnt <= '0;
    end else begin
      if (w_upd_product) r_product <= w_product_val;
      if (w_load)        r_iter_cnt <= '0;
      else if (w_step)   r_iter_cnt <= r_iter_cnt + CNT_W'(1);
    end
  end

  assign busy     = (r_state == ITER);
  assign done     = (r_state == DONE);
  assign product  = r_product;
  assign iter_cnt = r_iter_cnt;

endmodule
